// File: rtl/mux_pipe_n.sv
// mux_pipe_n: two-stage pipelined N:1 word multiplexer with valid/ready flow control.
// Stage 1 captures the addressed GROUP-word group, stage 2 picks the word inside it.
module mux_pipe_n #(
  parameter int WIDTH = 64,
  parameter int N     = 32,
  parameter int GROUP = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  output logic               out_err,
  output logic               out_valid,
  input  logic               out_ready
);
  localparam int GSEL_W = $clog2(GROUP);

  logic             r_s1_valid;
  logic [SEL_W-1:0] r_s1_sel;
  logic             r_s1_err;
  logic [WIDTH-1:0] r_s1_grp [GROUP];
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_data;
  logic [SEL_W-1:0] r_s2_sel;
  logic             r_s2_err;

  logic             w_s2_adv;
  logic             w_accept;
  logic             w_err;
  logic [SEL_W-1:0] w_base;
  logic [WIDTH-1:0] w_words [N];
  logic [WIDTH-1:0] w_grp   [GROUP];

  for (genvar k = 0; k < N; k++) begin : g_unpack
    assign w_words[k] = in_data[k*WIDTH +: WIDTH];
  end

  assign w_s2_adv = r_s1_valid & (~r_s2_valid | out_ready);
  assign in_ready = ~r_s1_valid | w_s2_adv;
  assign w_accept = in_valid & in_ready;
  assign w_err    = (32'(in_sel) >= 32'(N));
  assign w_base   = in_sel & ~SEL_W'(GROUP - 1);

  // Gather the addressed group; an out-of-range select yields all-zero words, never X.
  always_comb begin
    for (int g = 0; g < GROUP; g++) begin
      if (w_err) begin
        w_grp[g] = {WIDTH{1'b0}};
      end else begin
        w_grp[g] = w_words[w_base | SEL_W'(g)];
      end
    end
  end

  // Stage 1 register: group words, select and error flag captured on accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_sel   <= {SEL_W{1'b0}};
      r_s1_err   <= 1'b0;
      for (int g = 0; g < GROUP; g++) begin
        r_s1_grp[g] <= {WIDTH{1'b0}};
      end
    end else begin
      r_s1_valid <= w_accept | (r_s1_valid & ~w_s2_adv);
      if (w_accept) begin
        r_s1_sel <= in_sel;
        r_s1_err <= w_err;
        for (int g = 0; g < GROUP; g++) begin
          r_s1_grp[g] <= w_grp[g];
        end
      end
    end
  end

  // Stage 2 register: final word selection; holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= {WIDTH{1'b0}};
      r_s2_sel   <= {SEL_W{1'b0}};
      r_s2_err   <= 1'b0;
    end else begin
      r_s2_valid <= w_s2_adv | (r_s2_valid & ~out_ready);
      if (w_s2_adv) begin
        r_s2_data <= r_s1_grp[r_s1_sel[GSEL_W-1:0]];
        r_s2_sel  <= r_s1_sel;
        r_s2_err  <= r_s1_err;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out_data  = r_s2_data;
  assign out_sel   = r_s2_sel;
  assign out_err   = r_s2_err;
endmodule

// File: tb/tb_mux_pipe_n.sv
// Scoreboard bench for mux_pipe_n: a 32-word instance and a 24-word instance share
// stimulus; expected words are pushed on accept and popped by per-instance monitors.
module tb_mux_pipe_n;
  typedef struct packed {
    logic [63:0] d;
    logic [4:0]  s;
    logic        e;
  } item_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [63:0]   words [32];
  logic [2047:0] in_data_v;
  logic [4:0]    in_sel;
  logic          in_valid;
  logic          out_ready;
  logic          in_ready_a, out_valid_a, out_err_a;
  logic [63:0]   out_data_a;
  logic [4:0]    out_sel_a;
  logic          in_ready_b, out_valid_b, out_err_b;
  logic [63:0]   out_data_b;
  logic [4:0]    out_sel_b;

  item_t qa [$];
  item_t qb [$];
  int    pop_cyc_q [$];
  int    n_cmp = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    acc_cnt = 0;
  int    stall_cnt = 0;
  bit    rnd_ready = 1'b0;

  for (genvar k = 0; k < 32; k++) begin : g_pack
    assign in_data_v[k*64 +: 64] = words[k];
  end

  mux_pipe_n #(.WIDTH(64), .N(32), .GROUP(4)) u_dut_a (
    .clk(clk), .reset(reset), .in_data(in_data_v), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready_a), .out_data(out_data_a),
    .out_sel(out_sel_a), .out_err(out_err_a), .out_valid(out_valid_a),
    .out_ready(out_ready)
  );

  mux_pipe_n #(.WIDTH(64), .N(24), .GROUP(4)) u_dut_b (
    .clk(clk), .reset(reset), .in_data(in_data_v[24*64-1:0]), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready_b), .out_data(out_data_b),
    .out_sel(out_sel_b), .out_err(out_err_b), .out_valid(out_valid_b),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fill_pattern();
    for (int k = 0; k < 32; k++) words[k] = 64'(k) * 64'h0101;
  endtask

  // Present one request and wait (bounded) for it to be accepted.
  task automatic send(input logic [4:0] sel);
    item_t ia, ib;
    bit    done = 1'b0;
    int    guard = 0;
    in_sel   = sel;
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready_a === 1'b1) begin
        check("in_ready_b", 64'(in_ready_b), 64'd1);
        ia.d = words[sel]; ia.s = sel; ia.e = 1'b0;
        ib.e = (sel >= 5'd24);
        ib.d = ib.e ? 64'h0 : words[sel];
        ib.s = sel;
        qa.push_back(ia);
        qb.push_back(ib);
        acc_cnt++;
        done = 1'b1;
      end else begin
        stall_cnt++;
        guard++;
        if (guard > 200) begin
          n_cmp++; n_fail++;
          $display("FAIL accept_timeout: sel %0d never accepted", sel);
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int guard = 0;
    while ((qa.size() != 0 || qb.size() != 0) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("drain_a", 64'(qa.size()), 64'd0);
    check("drain_b", 64'(qb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor for the 32-word instance: scoreboard pop plus stall-hold check.
  initial begin
    item_t       it;
    bit          hold_v = 1'b0;
    logic [63:0] hold_d;
    logic [4:0]  hold_s;
    logic        hold_e;
    forever begin
      @(negedge clk);
      if (hold_v) begin
        check("hold_valid", 64'(out_valid_a), 64'd1);
        check("hold_data", out_data_a, hold_d);
        check("hold_sel", 64'(out_sel_a), 64'(hold_s));
        check("hold_err", 64'(out_err_a), 64'(hold_e));
      end
      hold_v = 1'b0;
      if (reset === 1'b0 && out_valid_a === 1'b1) begin
        if (out_ready === 1'b1) begin
          if (qa.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL a_unexpected: got sel %0d expected no output", out_sel_a);
          end else begin
            it = qa.pop_front();
            check("a_data", out_data_a, it.d);
            check("a_sel", 64'(out_sel_a), 64'(it.s));
            check("a_err", 64'(out_err_a), 64'(it.e));
            pop_cyc_q.push_back(cyc);
          end
        end else begin
          hold_v = 1'b1;
          hold_d = out_data_a; hold_s = out_sel_a; hold_e = out_err_a;
        end
      end
    end
  end

  // Monitor for the 24-word instance.
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && out_valid_b === 1'b1 && out_ready === 1'b1) begin
        if (qb.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL b_unexpected: got sel %0d expected no output", out_sel_b);
        end else begin
          it = qb.pop_front();
          check("b_data", out_data_b, it.d);
          check("b_sel", 64'(out_sel_b), 64'(it.s));
          check("b_err", 64'(out_err_b), 64'(it.e));
        end
      end
    end
  end

  // Random consumer backpressure, applied off the active edge.
  initial forever begin
    @(posedge clk);
    #2;
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    int s0, p0, a0;
    fill_pattern();
    reset = 1'b1; in_valid = 1'b0; in_sel = 5'd0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid_a), 64'd0);
    check("rst_out_data", out_data_a, 64'd0);
    check("rst_in_ready", 64'(in_ready_a), 64'd1);
    @(posedge clk);
    #1;

    // Single request: valid exactly two cycles after accept.
    send(5'd5);
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_t1_valid", 64'(out_valid_a), 64'd0);
    @(negedge clk);
    check("lat_t2_valid", 64'(out_valid_a), 64'd1);
    check("lat_t2_data", out_data_a, 64'h0505);
    check("lat_t2_sel", 64'(out_sel_a), 64'd5);
    @(posedge clk);
    #1;

    // Full-rate stream 0..31.
    s0 = stall_cnt;
    p0 = pop_cyc_q.size();
    for (int i = 0; i < 32; i++) send(5'(i));
    in_valid = 1'b0;
    drain();
    check("stream_stalls", 64'(stall_cnt - s0), 64'd0);
    if (pop_cyc_q.size() >= p0 + 32) begin
      check("stream_span", 64'(pop_cyc_q[p0+31] - pop_cyc_q[p0]), 64'd31);
    end else begin
      n_cmp++; n_fail++;
      $display("FAIL stream_count: got %0d outputs expected 32", pop_cyc_q.size() - p0);
    end

    // Consumer stalls for five cycles starting with an empty pipeline.
    out_ready = 1'b0;
    a0 = acc_cnt;
    fork
      begin
        for (int i = 0; i < 8; i++) send(5'(10 + i));
        in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("bp_accepts", 64'(acc_cnt - a0), 64'd2);
        check("bp_in_ready", 64'(in_ready_a), 64'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset with both stages full drops everything.
    out_ready = 1'b0;
    send(5'd3);
    send(5'd7);
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    qa.delete();
    qb.delete();
    @(negedge clk);
    check("rst2_out_valid", 64'(out_valid_a), 64'd0);
    check("rst2_out_data", out_data_a, 64'd0);
    check("rst2_out_sel", 64'(out_sel_a), 64'd0);
    check("rst2_out_err", 64'(out_err_a), 64'd0);
    check("rst2_in_ready", 64'(in_ready_a), 64'd1);
    @(posedge clk);
    #1 out_ready = 1'b1;

    // Out-of-range select on the 24-word instance, then its last valid word.
    send(5'd27);
    send(5'd23);
    in_valid = 1'b0;
    @(negedge clk);
    check("n24_err_flag", 64'(out_err_b), 64'd1);
    check("n24_err_data", out_data_b, 64'd0);
    check("n24_err_sel", 64'(out_sel_b), 64'd27);
    check("n32_sel27_data", out_data_a, 64'h1b1b);
    @(negedge clk);
    check("n24_ok_flag", 64'(out_err_b), 64'd0);
    check("n24_ok_data", out_data_b, 64'h1717);
    @(posedge clk);
    #1;
    drain();

    // Random valid gaps, data and backpressure.
    rnd_ready = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      for (int k = 0; k < 32; k++) words[k] = {$urandom, $urandom};
      send(5'($urandom_range(0, 31)));
    end
    in_valid = 1'b0;
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
